// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, polarity-programmable syncs,
// line/frame strobes, frame counter and a latency-matched copy of the flags.
module video_timing_gen #(
   parameter int   ACTIVE_H_PIXELS = 1280,
   parameter int   H_FRONT_PORCH   = 110,
   parameter int   H_SYNC_WIDTH    = 40,
   parameter int   H_BACK_PORCH    = 220,
   parameter int   ACTIVE_LINES    = 720,
   parameter int   V_FRONT_PORCH   = 5,
   parameter int   V_SYNC_WIDTH    = 5,
   parameter int   V_BACK_PORCH    = 20,
   parameter logic H_SYNC_POL      = 1'b1,
   parameter logic V_SYNC_POL      = 1'b1,
   parameter int   FRAME_CNT_W     = 8,
   parameter int   DELAY           = 0,
   localparam int  TOTAL_PIXELS    = ACTIVE_H_PIXELS + H_FRONT_PORCH
                                   + H_SYNC_WIDTH + H_BACK_PORCH,
   localparam int  TOTAL_LINES     = ACTIVE_LINES + V_FRONT_PORCH
                                   + V_SYNC_WIDTH + V_BACK_PORCH,
   localparam int  HW              = $clog2(TOTAL_PIXELS),
   localparam int  VW              = $clog2(TOTAL_LINES)
) (
   input  logic                   pixel_clk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic [HW-1:0]          h_count,
   output logic [VW-1:0]          v_count,
   output logic                   active_draw,
   output logic                   h_sync,
   output logic                   v_sync,
   output logic                   line_end,
   output logic                   new_frame,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   active_draw_d,
   output logic                   h_sync_d,
   output logic                   v_sync_d,
   output logic                   line_end_d,
   output logic                   new_frame_d
);

   if (H_FRONT_PORCH < 1 || H_SYNC_WIDTH < 1 || H_BACK_PORCH < 1 ||
       V_FRONT_PORCH < 1 || V_SYNC_WIDTH < 1 || V_BACK_PORCH < 1 ||
       DELAY < 0) begin : g_bad_cfg
      $error("video_timing_gen: porch/sync widths must be >=1, DELAY >=0");
   end

   localparam logic [HW-1:0] H_ACT  = HW'(ACTIVE_H_PIXELS);
   localparam logic [HW-1:0] HS_S   = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
   localparam logic [HW-1:0] HS_E   = HW'(ACTIVE_H_PIXELS + H_FRONT_PORCH
                                          + H_SYNC_WIDTH);
   localparam logic [HW-1:0] H_LAST = HW'(TOTAL_PIXELS - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(ACTIVE_LINES);
   localparam logic [VW-1:0] V_LACT = VW'(ACTIVE_LINES - 1);
   localparam logic [VW-1:0] VS_S   = VW'(ACTIVE_LINES + V_FRONT_PORCH);
   localparam logic [VW-1:0] VS_E   = VW'(ACTIVE_LINES + V_FRONT_PORCH
                                          + V_SYNC_WIDTH);
   localparam logic [VW-1:0] V_LAST = VW'(TOTAL_LINES - 1);
   localparam logic [4:0]    FLAGS_RST = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL, 2'b00};

   logic                   running;
   logic [HW-1:0]          h_q;
   logic [VW-1:0]          v_q;
   logic [FRAME_CNT_W-1:0] frame_q;
   logic                   hs_win;
   logic                   vs_win;
   logic [4:0]             flags;
   logic [4:0]             flags_d;

   // The first enabled edge only arms the counters so (0,0) is shown once.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= '0;
      end else if (en) begin
         if (!running) begin
            running <= 1'b1;
         end else begin
            if (new_frame)
               frame_q <= frame_q + FRAME_CNT_W'(1);
            if (h_q == H_LAST) begin
               h_q <= '0;
               v_q <= (v_q == V_LAST) ? '0 : v_q + VW'(1);
            end else begin
               h_q <= h_q + HW'(1);
            end
         end
      end
   end

   assign hs_win      = running && h_q >= HS_S && h_q < HS_E;
   assign vs_win      = running && v_q >= VS_S && v_q < VS_E;
   assign active_draw = running && h_q < H_ACT && v_q < V_ACT;
   assign h_sync      = hs_win ? H_SYNC_POL : ~H_SYNC_POL;
   assign v_sync      = vs_win ? V_SYNC_POL : ~V_SYNC_POL;
   assign line_end    = running && h_q == H_ACT && v_q < V_ACT;
   assign new_frame   = running && h_q == H_ACT && v_q == V_LACT;

   assign h_count     = h_q;
   assign v_count     = v_q;
   assign frame_count = frame_q;
   assign flags       = {active_draw, h_sync, v_sync, line_end, new_frame};

   if (DELAY <= 0) begin : g_nodly
      assign flags_d = flags;
   end else begin : g_dly
      logic [4:0] dly_q [DELAY];

      always_ff @(posedge pixel_clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DELAY; i++)
               dly_q[i] <= FLAGS_RST;
         end else if (en) begin
            dly_q[0] <= flags;
            for (int i = 1; i < DELAY; i++)
               dly_q[i] <= dly_q[i-1];
         end
      end

      assign flags_d = dly_q[DELAY-1];
   end

   assign {active_draw_d, h_sync_d, v_sync_d, line_end_d, new_frame_d} = flags_d;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: 16x8 raster, one active-high DELAY=3 unit
// with a 2-bit frame counter and one active-low DELAY=0 unit side by side.
module tb_video_timing_gen;

   logic       pixel_clk = 1'b0;
   logic       rst_n;
   logic       en;

   logic [3:0] a_h, b_h;
   logic [2:0] a_v, b_v;
   logic [1:0] a_fc;
   logic [7:0] b_fc;
   logic a_ad, a_hs, a_vs, a_le, a_nf, a_ad_d, a_hs_d, a_vs_d, a_le_d, a_nf_d;
   logic b_ad, b_hs, b_vs, b_le, b_nf, b_ad_d, b_hs_d, b_vs_d, b_le_d, b_nf_d;

   always #5 pixel_clk = ~pixel_clk;

   video_timing_gen #(
      .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3),
      .H_BACK_PORCH(3), .ACTIVE_LINES(4), .V_FRONT_PORCH(1),
      .V_SYNC_WIDTH(2), .V_BACK_PORCH(1), .H_SYNC_POL(1'b1),
      .V_SYNC_POL(1'b1), .FRAME_CNT_W(2), .DELAY(3)
   ) dut_a (
      .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
      .h_count(a_h), .v_count(a_v), .active_draw(a_ad),
      .h_sync(a_hs), .v_sync(a_vs), .line_end(a_le),
      .new_frame(a_nf), .frame_count(a_fc),
      .active_draw_d(a_ad_d), .h_sync_d(a_hs_d), .v_sync_d(a_vs_d),
      .line_end_d(a_le_d), .new_frame_d(a_nf_d)
   );

   video_timing_gen #(
      .ACTIVE_H_PIXELS(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3),
      .H_BACK_PORCH(3), .ACTIVE_LINES(4), .V_FRONT_PORCH(1),
      .V_SYNC_WIDTH(2), .V_BACK_PORCH(1), .H_SYNC_POL(1'b0),
      .V_SYNC_POL(1'b0), .FRAME_CNT_W(8), .DELAY(0)
   ) dut_b (
      .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en),
      .h_count(b_h), .v_count(b_v), .active_draw(b_ad),
      .h_sync(b_hs), .v_sync(b_vs), .line_end(b_le),
      .new_frame(b_nf), .frame_count(b_fc),
      .active_draw_d(b_ad_d), .h_sync_d(b_hs_d), .v_sync_d(b_vs_d),
      .line_end_d(b_le_d), .new_frame_d(b_nf_d)
   );

   int errs = 0;
   int checks = 0;

   bit m_run;
   int m_h, m_v, m_fc;
   logic [4:0] hist [$];

   bit tally_on;
   int ad_cnt, hs_cnt, vs_cnt, le_cnt, nf_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected {active, hsync, vsync, line_end, new_frame} for active-high syncs.
   function automatic logic [4:0] mflags(input bit run, input int h,
                                         input int v);
      if (!run)
         return 5'b0;
      return {h < 8 && v < 4, h >= 10 && h <= 12, v >= 5 && v <= 6,
              h == 8 && v < 4, h == 8 && v == 3};
   endfunction

   task automatic model_reset();
      m_run = 1'b0;
      m_h   = 0;
      m_v   = 0;
      m_fc  = 0;
      hist.delete();
      hist.push_back(5'b0);
   endtask

   task automatic step();
      bit e;
      e = en && rst_n;
      @(posedge pixel_clk);
      if (e) begin
         if (!m_run) begin
            m_run = 1'b1;
         end else begin
            if (m_h == 8 && m_v == 3)
               m_fc++;
            if (m_h == 15) begin
               m_h = 0;
               m_v = (m_v == 7) ? 0 : m_v + 1;
            end else begin
               m_h++;
            end
         end
         hist.push_back(mflags(m_run, m_h, m_v));
      end
      #1;
   endtask

   task automatic check_all();
      logic [4:0] f, fd;
      f  = mflags(m_run, m_h, m_v);
      fd = (hist.size() >= 4) ? hist[hist.size()-4] : 5'b0;
      check("a_h", 32'(a_h), 32'(m_h));
      check("a_v", 32'(a_v), 32'(m_v));
      check("b_h", 32'(b_h), 32'(m_h));
      check("b_v", 32'(b_v), 32'(m_v));
      check("a_fc", 32'(a_fc), 32'(m_fc % 4));
      check("b_fc", 32'(b_fc), 32'(m_fc % 256));
      check("a_flags", 32'({a_ad, a_hs, a_vs, a_le, a_nf}), 32'(f));
      check("a_flags_d", 32'({a_ad_d, a_hs_d, a_vs_d, a_le_d, a_nf_d}), 32'(fd));
      check("b_flags", 32'({b_ad, b_hs, b_vs, b_le, b_nf}), 32'(f ^ 5'b01100));
      check("b_flags_d", 32'({b_ad_d, b_hs_d, b_vs_d, b_le_d, b_nf_d}),
            32'(f ^ 5'b01100));
      if (tally_on) begin
         if (a_ad) ad_cnt++;
         if (a_hs) hs_cnt++;
         if (a_vs) vs_cnt++;
         if (a_le) le_cnt++;
         if (a_nf) nf_cnt++;
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_a_pos"}, 32'({a_h, a_v}), 32'd0);
      check({tag, "_b_pos"}, 32'({b_h, b_v}), 32'd0);
      check({tag, "_a_fc"}, 32'(a_fc), 32'd0);
      check({tag, "_b_fc"}, 32'(b_fc), 32'd0);
      check({tag, "_a_flags"}, 32'({a_ad, a_hs, a_vs, a_le, a_nf}), 32'h00);
      check({tag, "_a_flags_d"}, 32'({a_ad_d, a_hs_d, a_vs_d, a_le_d, a_nf_d}),
            32'h00);
      check({tag, "_b_flags"}, 32'({b_ad, b_hs, b_vs, b_le, b_nf}), 32'h0c);
      check({tag, "_b_flags_d"}, 32'({b_ad_d, b_hs_d, b_vs_d, b_le_d, b_nf_d}),
            32'h0c);
   endtask

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      tally_on = 1'b0;
      model_reset();
      repeat (3) step();
      check_reset("rst");

      rst_n = 1'b1;
      en    = 1'b1;
      check("pre_start_ad", 32'(a_ad), 32'd0);
      step();
      check("start_pos", 32'({a_h, a_v}), 32'd0);
      check("start_ad", 32'(a_ad), 32'd1);
      ad_cnt = 0; hs_cnt = 0; vs_cnt = 0; le_cnt = 0; nf_cnt = 0;
      tally_on = 1'b1;
      check_all();
      step();
      check("first_adv_h", 32'(a_h), 32'd1);
      check_all();
      repeat (14) begin step(); check_all(); end
      check("h_last", 32'(a_h), 32'd15);
      check("v_line0", 32'(a_v), 32'd0);
      step();
      check_all();
      check("h_wrap", 32'(a_h), 32'd0);
      check("v_inc", 32'(a_v), 32'd1);
      repeat (111) begin step(); check_all(); end
      tally_on = 1'b0;
      check("frame_end_h", 32'(a_h), 32'd15);
      check("frame_end_v", 32'(a_v), 32'd7);
      check("ad_cnt", 32'(ad_cnt), 32'd32);
      check("hs_cnt", 32'(hs_cnt), 32'd24);
      check("vs_cnt", 32'(vs_cnt), 32'd32);
      check("le_cnt", 32'(le_cnt), 32'd4);
      check("nf_cnt", 32'(nf_cnt), 32'd1);
      step();
      check_all();
      check("frame_wrap_pos", 32'({a_h, a_v}), 32'd0);
      check("fc_1", 32'(a_fc), 32'd1);

      for (int f = 2; f <= 4; f++) begin
         repeat (128) begin step(); check_all(); end
         check("fc_a_frames", 32'(a_fc), 32'(f % 4));
         check("fc_b_frames", 32'(b_fc), 32'(f));
      end

      nf_cnt = 0;
      tally_on = 1'b1;
      for (int i = 0; i < 256; i++) begin
         en = (i % 2 == 1);
         step();
         check_all();
         if (i == 0) check("tog_hold_h", 32'(a_h), 32'd0);
         if (i == 1) check("tog_adv_h", 32'(a_h), 32'd1);
      end
      tally_on = 1'b0;
      en = 1'b1;
      check("tog_nf_cnt", 32'(nf_cnt), 32'd2);
      check("tog_fc_a", 32'(a_fc), 32'd1);
      check("tog_fc_b", 32'(b_fc), 32'd5);
      check("tog_pos", 32'({a_h, a_v}), 32'd0);

      for (int i = 0; i < 200 && !(m_h == 5 && m_v == 2); i++) begin
         step();
         check_all();
      end
      check("pre_rst_h", 32'(a_h), 32'd5);
      check("pre_rst_v", 32'(a_v), 32'd2);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset("async_rst");
      #4;
      rst_n = 1'b1;
      check("restart_pre_ad", 32'(a_ad), 32'd0);
      step();
      check("restart_pos", 32'({a_h, a_v}), 32'd0);
      check("restart_ad", 32'(a_ad), 32'd1);
      check_all();
      repeat (40) begin step(); check_all(); end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
